wbc_rst_seq: RTL

- Staged reset sequencer that sits downstream of the system clock/reset controller.
- It takes the system-level "go" condition (sys_rst deasserted) and the 1 ms enable strobe, then releases STAGES peripheral reset domains one at a time, in order (e.g. SDRAM controller, bus fabric, CPU, peripherals).
- It waits for each domain's ready handshake before releasing the next, and detects ready timeouts.
- On a warm-reset request it reasserts the domains in reverse order.

---
 rtl/wbc_rst_seq_if.sv | 32 +++
 rtl/wbc_rst_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/wbc_rst_seq_if.sv
// Reset-domain bundle between the staged reset sequencer and its domains.
// master: stage_rst/stage_idx/done/fail/fail_stage out, stage_ready in.
interface wbc_rst_seq_if #(
    parameter int STAGES = 4
);
    localparam int IW = (STAGES > 1) ? $clog2(STAGES) : 1;

    logic [STAGES-1:0] stage_rst;
    logic [STAGES-1:0] stage_ready;
    logic [IW-1:0]     stage_idx;
    logic              done;
    logic              fail;
    logic [IW-1:0]     fail_stage;

    modport master (
        output stage_rst,
        output stage_idx,
        output done,
        output fail,
        output fail_stage,
        input  stage_ready
    );

    modport slave (
        input  stage_rst,
        input  stage_idx,
        input  done,
        input  fail,
        input  fail_stage,
        output stage_ready
    );
endinterface

// File: rtl/wbc_rst_seq.sv
// Staged reset sequencer: releases reset domains in order, waits for ready.
// Ports: clk, rst_n, sys_go, ena_ms, req_rst; dom (master) carries domain signals.
module wbc_rst_seq #(
    parameter int STAGES  = 4,
    parameter int HOLD    = 2,
    parameter int GAP     = 1,
    parameter int TIMEOUT = 100
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sys_go,
    input  logic          ena_ms,
    input  logic          req_rst,
    wbc_rst_seq_if.master dom
);
    localparam int IW   = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam int M1   = (HOLD > GAP) ? HOLD : GAP;
    localparam int MAXV = (M1 > TIMEOUT) ? M1 : TIMEOUT;
    localparam int CW   = (MAXV > 1) ? $clog2(MAXV) : 1;

    localparam logic [IW-1:0] LAST     = IW'(STAGES - 1);
    localparam logic [CW-1:0] HOLD_END = CW'(HOLD - 1);
    localparam logic [CW-1:0] GAP_END  = CW'(GAP - 1);
    localparam logic [CW-1:0] TO_END   = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_HOLD,
        S_REL,
        S_WAIT,
        S_GAP,
        S_RUN,
        S_FAIL,
        S_DOWN
    } state_t;

    state_t            state, state_d;
    logic [CW-1:0]     cnt, cnt_d;
    logic [IW-1:0]     idx, idx_d;
    logic [STAGES-1:0] rst_q, rst_d;
    logic              done_q, done_d;
    logic              fail_q, fail_d;
    logic [IW-1:0]     fstg_q, fstg_d;
    logic [IW-1:0]     idx_m1;
    logic              go_down;

    assign idx_m1 = idx - 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_HOLD;
            cnt    <= '0;
            idx    <= '0;
            rst_q  <= '1;
            done_q <= 1'b0;
            fail_q <= 1'b0;
            fstg_q <= '0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            idx    <= idx_d;
            rst_q  <= rst_d;
            done_q <= done_d;
            fail_q <= fail_d;
            fstg_q <= fstg_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        idx_d   = idx;
        rst_d   = rst_q;
        done_d  = done_q;
        fail_d  = fail_q;
        fstg_d  = fstg_q;
        go_down = 1'b0;
        if (!sys_go) begin
            // Losing the system go drops everything at once, no reverse walk.
            state_d = S_HOLD;
            cnt_d   = '0;
            idx_d   = '0;
            rst_d   = '1;
            done_d  = 1'b0;
            fail_d  = 1'b0;
        end else begin
            unique case (state)
                S_HOLD: begin
                    if (ena_ms) begin
                        if (cnt == HOLD_END) begin
                            cnt_d   = '0;
                            idx_d   = '0;
                            state_d = S_REL;
                        end else begin
                            cnt_d = cnt + 1'b1;
                        end
                    end
                end
                S_REL: begin
                    rst_d[idx] = 1'b0;
                    cnt_d      = '0;
                    state_d    = S_WAIT;
                end
                S_WAIT: begin
                    // Ready takes precedence over a coincident timeout.
                    if (dom.stage_ready[idx]) begin
                        if (idx == LAST) begin
                            done_d  = 1'b1;
                            state_d = S_RUN;
                        end else begin
                            cnt_d   = '0;
                            state_d = S_GAP;
                        end
                    end else if (ena_ms) begin
                        if (cnt == TO_END) begin
                            rst_d[idx] = 1'b1;
                            fail_d     = 1'b1;
                            fstg_d     = idx;
                            state_d    = S_FAIL;
                        end else begin
                            cnt_d = cnt + 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (ena_ms) begin
                        if (cnt == GAP_END) begin
                            cnt_d   = '0;
                            idx_d   = idx + 1'b1;
                            state_d = S_REL;
                        end else begin
                            cnt_d = cnt + 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (req_rst) begin
                        done_d  = 1'b0;
                        go_down = 1'b1;
                    end
                end
                S_FAIL: begin
                    if (req_rst) begin
                        fail_d  = 1'b0;
                        go_down = 1'b1;
                    end
                end
                S_DOWN: begin
                    if (ena_ms) begin
                        if (cnt == GAP_END) begin
                            cnt_d = '0;
                            if (idx == '0) begin
                                state_d = S_HOLD;
                            end else begin
                                idx_d         = idx_m1;
                                rst_d[idx_m1] = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                    idx_d   = '0;
                    rst_d   = '1;
                end
            endcase
            // Reverse walk starts by re-asserting the top domain.
            if (go_down) begin
                state_d     = S_DOWN;
                cnt_d       = '0;
                idx_d       = LAST;
                rst_d[LAST] = 1'b1;
            end
        end
    end

    assign dom.stage_rst  = rst_q;
    assign dom.stage_idx  = idx;
    assign dom.done       = done_q;
    assign dom.fail       = fail_q;
    assign dom.fail_stage = fstg_q;
endmodule
